data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/dmr_pkg.sv | 17 +
 rtl/mem_sram_array.sv | 35 +++
 rtl/data_mem_responder.sv | 146 ++++++++++++++
 tb/tb_data_mem_responder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmr_pkg.sv
// rtl/dmr_pkg.sv - shared types and constants for the data memory responder
// Purpose: state encoding, wait-state counter width and default depth used by
//          data_mem_responder and its storage array.
// Ports:   none (package).
package dmr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  // Wide enough for the full legal wait-state range 0..15.
  localparam int CNT_W         = 4;
  localparam int DEFAULT_DEPTH = 1024;

endpackage

// File: rtl/mem_sram_array.sv
// rtl/mem_sram_array.sv - DEPTH x 32 byte-enabled synchronous RAM, registered read
// Purpose: backing store for the data memory responder. Contents are never
//          reset, so they persist across controller resets.
// Ports:   clk   - clock
//          we    - per-byte write enables, bit i writes bits 8i+7:8i
//          re    - read enable; rdata updates only when set, otherwise holds
//          index - word index shared by read and write
//          wdata - lane-aligned write data
//          rdata - registered read word
module mem_sram_array #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic [3:0]       we,
  input  logic             re,
  input  logic [IDX_W-1:0] index,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        mem[index][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) begin
      rdata <= mem[index];
    end
  end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - wait-stated request/valid data memory responder
// Purpose: accepts one load/store at a time from a core, waits WAIT_STATES
//          cycles, then commits the write or returns the read word with a
//          one-cycle valid pulse.
// Ports:   clk        - clock
//          rst        - synchronous active-high reset (array not cleared)
//          request    - transaction request, held by the core until valid
//          we_re      - 1 = store, 0 = load
//          mask       - byte enables for stores
//          address    - byte address; bits IDX_W+1:2 select the word
//          store_data - lane-aligned store data
//          valid      - one-cycle response pulse
//          load_data  - read word (0 after a store), held until next response
module data_mem_responder
  import dmr_pkg::*;
#(
  parameter int DEPTH       = DEFAULT_DEPTH,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        request,
  input  logic        we_re,
  input  logic [3:0]  mask,
  input  logic [31:0] address,
  input  logic [31:0] store_data,
  output logic        valid,
  output logic [31:0] load_data
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;

  logic             we_q;
  logic [3:0]       mask_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      data_q;

  // 1 when the last response was a read, so load_data shows the RAM output;
  // 0 after reset or a store response, so load_data reads as zero.
  logic             rdata_sel_q;

  logic             accept;
  logic             enter_resp;
  logic             op_we;
  logic [3:0]       op_mask;
  logic [IDX_W-1:0] op_idx;
  logic [31:0]      op_data;
  logic [3:0]       mem_we;
  logic             mem_re;
  logic [31:0]      mem_rdata;

  // Bits outside the word index alias away.
  logic unused_addr;
  assign unused_addr = ^{address[31:IDX_W+2], address[1:0]};

  assign accept     = (state == IDLE) && request;
  assign enter_resp = !rst && (state != RESP) && (state_nx == RESP);

  // With zero wait states RESP is entered on the acceptance edge itself, before
  // the capture registers hold anything, so the live inputs feed the RAM then.
  always_comb begin
    if (state == IDLE) begin
      op_we   = we_re;
      op_mask = mask;
      op_idx  = address[IDX_W+1:2];
      op_data = store_data;
    end else begin
      op_we   = we_q;
      op_mask = mask_q;
      op_idx  = idx_q;
      op_data = data_q;
    end
  end

  assign mem_we = (enter_resp && op_we) ? op_mask : 4'b0000;
  assign mem_re = enter_resp && !op_we;

  mem_sram_array #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .index (op_idx),
    .wdata (op_data),
    .rdata (mem_rdata)
  );

  // State register, wait counter and capture registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      we_q        <= 1'b0;
      mask_q      <= 4'b0000;
      idx_q       <= '0;
      data_q      <= '0;
      rdata_sel_q <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        we_q   <= we_re;
        mask_q <= mask;
        idx_q  <= address[IDX_W+1:2];
        data_q <= store_data;
        cnt    <= CNT_W'(WAIT_STATES);
      end else if (state == BUSY) begin
        cnt <= cnt - 1'b1;
      end
      if (enter_resp) begin
        rdata_sel_q <= !op_we;
      end
    end
  end

  // BUSY lasts WAIT_STATES cycles; the counter reaches zero on the edge that
  // enters RESP, giving a WAIT_STATES+1 cycle request-to-valid latency.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (request) begin
          state_nx = (WAIT_STATES == 0) ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (cnt <= CNT_W'(1)) begin
          state_nx = RESP;
        end
      end
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    valid     = (state == RESP);
    load_data = rdata_sel_q ? mem_rdata : 32'h0;
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;

  localparam int WS_OF [2] = '{2, 0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_s  [2];
  logic        we_s   [2];
  logic [3:0]  mask_s [2];
  logic [31:0] addr_s [2];
  logic [31:0] data_s [2];
  logic        valid_s[2];
  logic [31:0] load_s [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(1024), .WAIT_STATES(2)) dut (
    .clk(clk), .rst(rst), .request(req_s[0]), .we_re(we_s[0]), .mask(mask_s[0]),
    .address(addr_s[0]), .store_data(data_s[0]), .valid(valid_s[0]), .load_data(load_s[0])
  );

  data_mem_responder #(.DEPTH(1024), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .request(req_s[1]), .we_re(we_s[1]), .mask(mask_s[1]),
    .address(addr_s[1]), .store_data(data_s[1]), .valid(valid_s[1]), .load_data(load_s[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Behavioural model: timeline arithmetic per instance. A transaction accepted
  // at edge a responds in the cycle after edge a+WS; the next acceptance can
  // happen no earlier than edge a+WS+2.
  longint      edge_n = 0;
  bit          started = 0;
  bit          pend      [2];
  longint      resp_edge [2];
  longint      next_free [2];
  logic        p_we      [2];
  logic [3:0]  p_mask    [2];
  logic [9:0]  p_idx     [2];
  logic [31:0] p_data    [2];
  logic        exp_valid [2];
  logic [31:0] exp_load  [2];
  bit          exp_known [2];
  logic [31:0] mem_m     [2][1024];
  logic [3:0]  known_m   [2][1024];

  initial begin
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; next_free[i] = 0; exp_valid[i] = 0; exp_load[i] = 0; exp_known[i] = 0;
      for (int k = 0; k < 1024; k++) begin
        mem_m[i][k] = '0; known_m[i][k] = 4'b0000;
      end
    end
    forever begin
      @(posedge clk);
      for (int i = 0; i < 2; i++) begin
        exp_valid[i] = 1'b0;
        if (rst) begin
          pend[i]      = 0;
          next_free[i] = edge_n + 1;
          exp_load[i]  = 32'h0;
          exp_known[i] = 1;
        end else begin
          if (!pend[i] && edge_n >= next_free[i] && req_s[i]) begin
            pend[i]      = 1;
            p_we[i]      = we_s[i];
            p_mask[i]    = mask_s[i];
            p_idx[i]     = addr_s[i][11:2];
            p_data[i]    = data_s[i];
            resp_edge[i] = edge_n + WS_OF[i];
            next_free[i] = edge_n + WS_OF[i] + 2;
          end
          if (pend[i] && edge_n == resp_edge[i]) begin
            pend[i]      = 0;
            exp_valid[i] = 1'b1;
            if (p_we[i]) begin
              for (int b = 0; b < 4; b++) begin
                if (p_mask[i][b]) begin
                  mem_m[i][p_idx[i]][8*b +: 8] = p_data[i][8*b +: 8];
                  known_m[i][p_idx[i]][b]      = 1'b1;
                end
              end
              exp_load[i]  = 32'h0;
              exp_known[i] = 1;
            end else begin
              exp_load[i]  = mem_m[i][p_idx[i]];
              exp_known[i] = (known_m[i][p_idx[i]] == 4'hF);
            end
          end
        end
      end
      edge_n++;
      started = 1;
    end
  end

  // Compare process: every cycle, both instances.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("valid_inst%0d_cyc%0d", i, edge_n), {31'h0, valid_s[i]}, {31'h0, exp_valid[i]});
          if (exp_known[i]) begin
            chk($sformatf("load_data_inst%0d_cyc%0d", i, edge_n), load_s[i], exp_load[i]);
          end
        end
      end
    end
  end

  task automatic txn(input int i, input logic w, input logic [3:0] m, input logic [31:0] a,
                     input logic [31:0] d, input bit scramble,
                     output logic [31:0] rd, output int lat);
    bit seen;
    seen = 0;
    rd   = '0;
    lat  = 0;
    @(negedge clk);
    req_s[i] = 1'b1; we_s[i] = w; mask_s[i] = m; addr_s[i] = a; data_s[i] = d;
    while (!seen && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (scramble && lat == 1) begin
        addr_s[i] = 32'h0000_0040;
        data_s[i] = $urandom;
      end
      if (valid_s[i]) begin
        seen = 1;
        rd   = load_s[i];
      end
    end
    req_s[i] = 1'b0;
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL txn_timeout inst=%0d actual=no_valid required=valid", i);
    end
  endtask

  logic [31:0] rd;
  int          lat;
  int          pulses;
  int          consec;
  logic        prev_v;

  initial begin
    for (int i = 0; i < 2; i++) begin
      req_s[i] = 0; we_s[i] = 0; mask_s[i] = 0; addr_s[i] = 0; data_s[i] = 0;
    end
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_valid0", {31'h0, valid_s[0]}, 32'h0);
    chk("reset_load0", load_s[0], 32'h0);
    chk("reset_valid1", {31'h0, valid_s[1]}, 32'h0);
    chk("reset_load1", load_s[1], 32'h0);
    rst = 1'b0;

    // Give the words used below a known value in both instances.
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 16; k++) begin
        txn(i, 1'b1, 4'hF, 32'(k) << 2, $urandom, 0, rd, lat);
      end
    end

    // Full write then read, latency WS+1.
    txn(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 0, rd, lat);
    chk("write_latency", 32'(lat), 32'd3);
    chk("write_load_zero", rd, 32'h0);
    txn(0, 1'b0, 4'h0, 32'h10, 32'h0, 0, rd, lat);
    chk("read_latency", 32'(lat), 32'd3);
    chk("read_deadbeef", rd, 32'hDEADBEEF);

    // Single-byte write.
    txn(0, 1'b1, 4'b0100, 32'h10, 32'h00AA0000, 0, rd, lat);
    txn(0, 1'b0, 4'hF, 32'h10, 32'h0, 0, rd, lat);
    chk("partial_write", rd, 32'hDEAABEEF);

    // No-op write still answers and changes nothing.
    txn(0, 1'b1, 4'b0000, 32'h10, 32'hFFFFFFFF, 0, rd, lat);
    chk("noop_write_latency", 32'(lat), 32'd3);
    txn(0, 1'b0, 4'h0, 32'h10, 32'h0, 0, rd, lat);
    chk("noop_write_data", rd, 32'hDEAABEEF);

    // Aliasing modulo DEPTH words.
    txn(0, 1'b1, 4'hF, 32'h1004, 32'hCAFEF00D, 0, rd, lat);
    txn(0, 1'b0, 4'h0, 32'h0004, 32'h0, 0, rd, lat);
    chk("alias_read", rd, 32'hCAFEF00D);

    // Address moved during BUSY has no effect.
    txn(0, 1'b1, 4'hF, 32'h40, 32'h11111111, 0, rd, lat);
    txn(0, 1'b0, 4'h0, 32'h10, 32'h0, 1, rd, lat);
    chk("captured_address", rd, 32'hDEAABEEF);

    // Reset one cycle after acceptance aborts the write.
    txn(0, 1'b1, 4'hF, 32'h20, 32'h0BADF00D, 0, rd, lat);
    @(negedge clk);
    req_s[0] = 1'b1; we_s[0] = 1'b1; mask_s[0] = 4'hF; addr_s[0] = 32'h20; data_s[0] = 32'h12345678;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    req_s[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid_s[0]) pulses++;
    end
    chk("abort_no_valid", 32'(pulses), 32'd0);
    txn(0, 1'b0, 4'h0, 32'h20, 32'h0, 0, rd, lat);
    chk("abort_no_commit", rd, 32'h0BADF00D);

    // Zero wait states: latency 1, and a held request answers every 2nd cycle.
    txn(1, 1'b1, 4'hF, 32'h8, 32'hA5A5A5A5, 0, rd, lat);
    chk("ws0_latency", 32'(lat), 32'd1);
    @(negedge clk);
    req_s[1] = 1'b1;
    pulses = 0;
    consec = 0;
    prev_v = 1'b0;
    for (int c = 0; c < 20; c++) begin
      we_s[1]   = $urandom_range(0, 1);
      mask_s[1] = 4'($urandom);
      addr_s[1] = {$urandom_range(0, 255), 24'h0} | (32'($urandom_range(0, 15)) << 2);
      data_s[1] = $urandom;
      @(posedge clk);
      @(negedge clk);
      if (valid_s[1]) pulses++;
      if (valid_s[1] && prev_v) consec++;
      prev_v = valid_s[1];
    end
    req_s[1] = 1'b0;
    chk("ws0_pulse_count", 32'(pulses), 32'd10);
    chk("ws0_no_consecutive", 32'(consec), 32'd0);

    // Randomised traffic on both instances, with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        logic [31:0] a;
        a = $urandom;
        a[11:2] = 10'($urandom_range(0, 15));
        req_s[i]  = ($urandom_range(0, 9) < 7);
        we_s[i]   = $urandom_range(0, 1);
        mask_s[i] = 4'($urandom);
        addr_s[i] = a;
        data_s[i] = $urandom;
      end
      rst = ($urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    req_s[0] = 1'b0;
    req_s[1] = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
